// File: rtl/jtag_tx_arb.sv
// jtag_tx_arb: shares the single JTAG serial transmit byte channel between two byte streams.
// Define JTAG_TX_ARB_PKTLOCK_EN to hold the grant per packet (EOP byte or idle timeout).
module jtag_tx_arb #(
   parameter logic [7:0] EOP        = 8'h0a,
   parameter int         TIMEOUT_LG = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_a0_stb,
   input  logic [7:0] i_a0_data,
   output logic       o_a0_busy,
   input  logic       i_a1_stb,
   input  logic [7:0] i_a1_data,
   output logic       o_a1_busy,
   output logic       o_tx_stb,
   output logic [7:0] o_tx_data,
   input  logic       i_tx_busy,
   output logic [1:0] o_owner
);

   // Handshake: a byte moves on any cycle where its strobe is high and the
   // matching busy is low (requesters: i_an_stb && !o_an_busy; serializer:
   // o_tx_stb && !i_tx_busy). Data must be stable while the strobe is high.
   logic       ovalid;
   logic [7:0] odata;
   logic       last;
   logic       acc0;
   logic       acc1;
   logic       acc;
   logic [7:0] abyte;

   assign o_tx_stb  = ovalid;
   assign o_tx_data = odata;
   assign acc0      = i_a0_stb && !o_a0_busy;
   assign acc1      = i_a1_stb && !o_a1_busy;
   assign acc       = acc0 || acc1;
   assign abyte     = acc0 ? i_a0_data : i_a1_data;

`ifdef JTAG_TX_ARB_PKTLOCK_EN
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t                state;
   logic [TIMEOUT_LG-1:0] timer;

   assign o_owner   = state;
   assign o_a0_busy = ovalid || (state == OWN1) || ((state == IDLE) && i_a1_stb && !last);
   assign o_a1_busy = ovalid || (state == OWN0) || ((state == IDLE) && i_a0_stb && last);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         last   <= 1'b1;
         ovalid <= 1'b0;
         odata  <= 8'hff;
         timer  <= '0;
      end else begin
         if (acc) begin
            ovalid <= 1'b1;
            odata  <= abyte;
         end else if (ovalid && !i_tx_busy) begin
            ovalid <= 1'b0;
         end
         case (state)
            IDLE: begin
               timer <= '0;
               // A lone EOP byte is a complete packet: no ownership taken.
               if (acc && (abyte != EOP)) begin
                  state <= acc0 ? OWN0 : OWN1;
               end else if (acc) begin
                  last <= acc1;
               end
            end
            OWN0, OWN1: begin
               if (acc) begin
                  timer <= '0;
                  if (abyte == EOP) begin
                     state <= IDLE;
                     last  <= (state == OWN1);
                  end
               end else if (&timer) begin
                  state <= IDLE;
                  last  <= (state == OWN1);
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic [7:0] unused_cfg;

   // Byte-level round-robin: packet framing parameters play no part here.
   assign unused_cfg = EOP ^ 8'(TIMEOUT_LG);
   assign o_owner    = 2'b00;
   assign o_a0_busy  = ovalid || (i_a1_stb && !last);
   assign o_a1_busy  = ovalid || (i_a0_stb && last);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         last   <= 1'b1;
         ovalid <= 1'b0;
         odata  <= 8'hff;
      end else begin
         if (acc) begin
            ovalid <= 1'b1;
            odata  <= abyte;
            last   <= acc1;
         end else if (ovalid && !i_tx_busy) begin
            ovalid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_jtag_tx_arb.sv
// tb_jtag_tx_arb: directed tests for jtag_tx_arb with a per-cycle reference model and byte scoreboard.
// Follows JTAG_TX_ARB_PKTLOCK_EN the same way the design does.
module tb_jtag_tx_arb;

   localparam int         TLG = 4;
   localparam logic [7:0] EOP = 8'h0a;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_a0_stb = 1'b0;
   logic [7:0] i_a0_data = 8'h00;
   logic       o_a0_busy;
   logic       i_a1_stb = 1'b0;
   logic [7:0] i_a1_data = 8'h00;
   logic       o_a1_busy;
   logic       o_tx_stb;
   logic [7:0] o_tx_data;
   logic       i_tx_busy = 1'b0;
   logic [1:0] o_owner;

   jtag_tx_arb #(.EOP(EOP), .TIMEOUT_LG(TLG)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_a0_stb  (i_a0_stb),
      .i_a0_data (i_a0_data),
      .o_a0_busy (o_a0_busy),
      .i_a1_stb  (i_a1_stb),
      .i_a1_data (i_a1_data),
      .o_a1_busy (o_a1_busy),
      .o_tx_stb  (o_tx_stb),
      .o_tx_data (o_tx_data),
      .i_tx_busy (i_tx_busy),
      .o_owner   (o_owner)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_a0_stb  = 1'b0;
      i_a1_stb  = 1'b0;
      i_tx_busy = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   // ---------------- scoreboard / model state ----------------
   logic [7:0] exp_q[$];
   int         acc_port[$];
   int         acc_cyc[$];
   int         own1_cnt = 0;
   int         own2_cnt = 0;

   bit         m_known = 1'b0;
   bit         m_vld;
   logic [7:0] m_dat;
   int         m_own;   // 0 free, 1 port 0 holds the line, 2 port 1 holds it
   int         m_last;  // port that most recently finished
   int         m_idle;  // idle cycles while a packet is open

`ifdef JTAG_TX_ARB_PKTLOCK_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   // A port may hand over a byte when the buffer is empty and the line is
   // either its own, or free and not contested by the fairer claimant.
   function automatic bit may_take(input int n, input bit other_req);
      if (m_vld) return 1'b0;
      if (PKT && (m_own != 0)) return (m_own == n + 1);
      if (other_req) return (m_last != n);
      return 1'b1;
   endfunction

   always @(negedge i_clk) begin
      bit         p0, p1, t0, t1;
      int         n;
      logic [7:0] b;
      p0 = may_take(0, i_a1_stb);
      p1 = may_take(1, i_a0_stb);
      if (m_known) begin
         chk("a0_busy", o_a0_busy, !p0);
         chk("a1_busy", o_a1_busy, !p1);
         chk("tx_stb", o_tx_stb, m_vld);
         chk("tx_data", o_tx_data, m_dat);
         chk("owner", o_owner, m_own);
      end
      if (i_rst_n) begin
         if (o_tx_stb && !i_tx_busy) begin
            if (exp_q.size() == 0) chk("unexpected_byte", o_tx_data, 32'hffff_ffff);
            else chk("stream", o_tx_data, exp_q.pop_front());
         end
         if (i_a0_stb && !o_a0_busy) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
         if (i_a1_stb && !o_a1_busy) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
         if (o_owner == 2'b01) own1_cnt++;
         if (o_owner == 2'b10) own2_cnt++;
      end
      // advance the model to the state after the coming clock edge
      if (!i_rst_n) begin
         m_known = 1'b1;
         m_vld   = 1'b0;
         m_dat   = 8'hff;
         m_own   = 0;
         m_last  = 1;
         m_idle  = 0;
      end else begin
         t0 = i_a0_stb && p0;
         t1 = i_a1_stb && p1;
         n  = t0 ? 0 : 1;
         b  = t0 ? i_a0_data : i_a1_data;
         if (t0 || t1) begin
            m_vld = 1'b1;
            m_dat = b;
         end else if (m_vld && !i_tx_busy) begin
            m_vld = 1'b0;
         end
         if (!PKT) begin
            if (t0 || t1) m_last = n;
         end else if (m_own == 0) begin
            if ((t0 || t1) && (b == EOP)) m_last = n;
            else if (t0 || t1) begin m_own = n + 1; m_idle = 0; end
         end else if (t0 || t1) begin
            m_idle = 0;
            if (b == EOP) begin m_last = m_own - 1; m_own = 0; end
         end else begin
            m_idle++;
            if (m_idle == (1 << TLG)) begin m_last = m_own - 1; m_own = 0; end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send0(input logic [7:0] b);
      int n = 0;
      i_a0_stb  = 1'b1;
      i_a0_data = b;
      forever begin
         @(negedge i_clk);
         if (!o_a0_busy) break;
         n++;
         if (n > 200) begin
            errors++;
            $display("FAIL port0_timeout: byte %0h never accepted", b);
            break;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic send1(input logic [7:0] b);
      int n = 0;
      i_a1_stb  = 1'b1;
      i_a1_data = b;
      forever begin
         @(negedge i_clk);
         if (!o_a1_busy) break;
         n++;
         if (n > 200) begin
            errors++;
            $display("FAIL port1_timeout: byte %0h never accepted", b);
            break;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle0(); i_a0_stb = 1'b0; i_a0_data = 8'h00; endtask
   task automatic idle1(); i_a1_stb = 1'b0; i_a1_data = 8'h00; endtask

   task automatic start_test();
      do_reset();
      acc_port.delete();
      acc_cyc.delete();
      own1_cnt = 0;
      own2_cnt = 0;
   endtask

   task automatic drain(input string name);
      repeat (4) @(posedge i_clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int c_rel;
      int stable;
      int exp_ports[6];

      // reset values, latency, and reset discarding a pending byte
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_tx_stb", o_tx_stb, 1'b0);
      chk("rst_tx_data", o_tx_data, 8'hff);
      chk("rst_owner", o_owner, 2'b00);
      start_test();
      i_tx_busy = 1'b1;
      send0(8'h55);
      idle0();
      @(negedge i_clk);
      chk("lat_tx_stb", o_tx_stb, 1'b1);
      chk("lat_tx_data", o_tx_data, 8'h55);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      chk("rst_pending_stb", o_tx_stb, 1'b0);
      chk("rst_pending_data", o_tx_data, 8'hff);
      @(posedge i_clk);
      #1;
      i_rst_n   = 1'b1;
      i_tx_busy = 1'b0;

`ifdef JTAG_TX_ARB_PKTLOCK_EN
      // "AB\n" on port 0 must not be split by port 1
      start_test();
      exp_q = '{8'h41, 8'h42, 8'h0a, 8'h58};
      fork
         begin send0(8'h41); send0(8'h42); send0(8'h0a); idle0(); end
         begin send1(8'h58); idle1(); end
      join
      drain("pkt_drain");
      chk("pkt_first_port", acc_port[0], 0);
      chk("pkt_p1_port", acc_port[3], 1);
      chk("pkt_byte_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("pkt_p1_after_eop", acc_cyc[3] - acc_cyc[2], 2);
      chk("pkt_own_cycles", own1_cnt, 4);

      // tie in idle: port 0 first after reset, port 1 after port 0's EOP
      start_test();
      exp_q = '{8'h30, 8'h0a, 8'h61, 8'h0a, 8'h33, 8'h0a};
      exp_ports = '{0, 0, 1, 1, 0, 0};
      fork
         begin send0(8'h30); send0(8'h0a); send0(8'h33); send0(8'h0a); idle0(); end
         begin send1(8'h61); send1(8'h0a); idle1(); end
      join
      drain("rr_drain");
      chk("rr_count", acc_port.size(), 6);
      for (int i = 0; i < 6; i++) chk("rr_port", acc_port[i], exp_ports[i]);

      // idle timeout releases port 1 after 2**TLG quiet cycles
      start_test();
      exp_q = '{8'h31, 8'h32, 8'h0a};
      send1(8'h31);
      idle1();
      send0(8'h32);
      send0(8'h0a);
      idle0();
      drain("tmo_drain");
      chk("tmo_own_cycles", own2_cnt, 16);
      chk("tmo_next_accept", acc_cyc[1] - acc_cyc[0], 17);
      chk("tmo_next_port", acc_port[1], 0);
`else
      // byte-level round-robin with both ports always requesting
      start_test();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h41);
         exp_q.push_back(8'h42);
      end
      fork
         begin for (int i = 0; i < 4; i++) send0(8'h41); idle0(); end
         begin for (int j = 0; j < 4; j++) send1(8'h42); idle1(); end
      join
      drain("alt_drain");
      chk("alt_count", acc_port.size(), 8);
      for (int i = 0; i < 8; i++) chk("alt_port", acc_port[i], i % 2);
      chk("alt_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("alt_owner", own1_cnt + own2_cnt, 0);
`endif

      // serializer stalled for 20 cycles with a byte in the buffer
      start_test();
      exp_q = '{8'h41, 8'h42, 8'h0a};
      i_tx_busy = 1'b1;
      send0(8'h41);
      stable = 0;
      c_rel  = 0;
      fork
         begin send0(8'h42); send0(8'h0a); idle0(); end
         begin
            repeat (20) begin
               @(negedge i_clk);
               if (o_tx_stb && (o_tx_data == 8'h41) && o_a0_busy && o_a1_busy) stable++;
            end
            @(posedge i_clk);
            #1;
            i_tx_busy = 1'b0;
            c_rel = cyc;
         end
      join
      drain("stall_drain");
      chk("stall_stable", stable, 20);
      chk("stall_next_accept", acc_cyc[1] - c_rel, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete by %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
